// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the fetch and IF/ID stages.
package pipe_pkg;

  localparam int unsigned PC_W     = 12;
  localparam int unsigned INST_W   = 19;
  localparam logic [PC_W-1:0] RESET_PC = PC_W'(0);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched entries; flush beats push/pop, reset clears storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_eff;

  assign empty     = (count == CNT_W'(0));
  assign full      = (count == CNT_W'(DEPTH));
  assign pop_eff   = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_eff) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_eff);
    end
  end

  // Upstream credit accounting must make overflow impossible.
  always_ff @(posedge clk) begin
    if (!reset && !flush) assert (!(push && full));
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads and buffers results for decode.
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [INST_W-1:0] out_instruction,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  logic [PC_W-1:0]  fetch_pc;
  logic             inflight;
  logic [PC_W-1:0]  inflight_pc;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             credit_ok;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Credits count the inflight read so a same-cycle pop never matters.
  assign credit_ok = !fifo_full &&
                     ((32'(fifo_count) + 32'(inflight)) < 32'(DEPTH));
  assign imem_req  = !reset && (redirect_valid || credit_ok);
  assign imem_addr = redirect_valid ? redirect_pc : fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc + PC_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= redirect_pc;
    end else if (credit_ok) begin
      fetch_pc    <= fetch_pc + PC_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  assign push_entry.pc          = inflight_pc;
  assign push_entry.instruction = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid       = !fifo_empty;
  assign out_pc          = head_entry.pc;
  assign out_instruction = head_entry.instruction;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata = '0;
  logic              out_valid;
  logic [INST_W-1:0] out_instruction;
  logic [PC_W-1:0]   out_pc;
  logic              out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Model: PCs sitting in the buffer, the PC whose read is in flight, next sequential PC.
  logic [PC_W-1:0] q[$];
  logic [PC_W-1:0] pend[$];
  logic [PC_W-1:0] m_pc = '0;
  bit              reset_seen = 0;
  bit              prev_rst = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] word(input logic [PC_W-1:0] a);
    return {a[6:0], a} ^ 19'h5a5a5;
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= word(imem_addr);
    else          imem_rdata <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rv, input logic [PC_W-1:0] rpc,
                      input logic rdy);
    logic exp_req;
    @(negedge clk);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
    exp_req = !rst && (rv || ((q.size() + pend.size()) < DEPTH));
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(rv ? rpc : m_pc));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_pc", 32'(out_pc), 32'(q[0]));
      chk("out_instruction", 32'(out_instruction), 32'(word(q[0])));
    end
    if (prev_rst) begin
      chk("reset_out_pc", 32'(out_pc), 32'(0));
      chk("reset_out_instruction", 32'(out_instruction), 32'(0));
    end
    if (reset_seen) chk("no_x_head", 32'($isunknown({out_pc, out_instruction})), 32'(0));

    // Advance the model across the rising edge.
    if (rst) begin
      q.delete(); pend.delete(); m_pc = RESET_PC; reset_seen = 1;
    end else if (rv) begin
      q.delete(); pend.delete(); pend.push_back(rpc); m_pc = rpc + PC_W'(1);
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (pend.size() != 0) q.push_back(pend.pop_front());
      if (exp_req) begin
        pend.push_back(m_pc);
        m_pc = m_pc + PC_W'(1);
      end
    end
    prev_rst = rst;
  endtask

  initial begin
    // Reset then free-running stream.
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, '0, 1);

    // Decode stalls: buffer fills and requests stop, then drain in order.
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0);
    chk("stall_fill_depth", 32'(q.size()), 32'(DEPTH));
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

    // Redirect with three entries buffered.
    for (int k = 0; k < 10 && q.size() != 3; k++) step(0, 0, '0, 0);
    step(0, 1, 12'h100, 0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

    // Back-to-back redirects: only the second target survives.
    step(0, 1, 12'h020, 1);
    step(0, 1, 12'h040, 1);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

    // PC wrap.
    step(0, 1, 12'hFFE, 1);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);

    // Reset mid-stream with a full buffer.
    for (int i = 0; i < 8; i++) step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rv;
      logic [PC_W-1:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? PC_W'(12'hFFC + $urandom_range(0, 5))
                                        : PC_W'($urandom_range(0, 4095));
      step(($urandom_range(0, 199) == 0), rv, rpc, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
